// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit; define MDU_EARLY_OUT_EN to retire div-by-zero/overflow without iterating
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [W2-1:0]     acc_q, acc_d;     // mul: {product_hi, multiplier}; div: {rem, quot}
    logic [XLEN-1:0]   dvs_q, dvs_d;     // multiplicand or divisor magnitude
    logic              neg_q, neg_d;     // sign to apply to the selected result
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d; // untouched dividend for REM by zero
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    // launch-time preprocessing signals
    logic              signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              neg_in, div0_in, ovf_in;

    // single iteration datapath signals
    logic              is_div;
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN+1:0]   add_a, add_b, sum;
    logic              no_borrow;
    logic [W2-1:0]     acc_step;

    logic              launch;

    // Final sign fix-up and result select; special cases bypass sign correction.
    function automatic logic [XLEN-1:0] finish_res(
        input logic [2:0]      f3,
        input logic [W2-1:0]   acc,
        input logic            neg,
        input logic            div0,
        input logic            ovf,
        input logic [XLEN-1:0] a_raw
    );
        logic [W2-1:0]   prod;
        logic [XLEN-1:0] part;
        if (div0) begin
            finish_res = f3[1] ? a_raw : {XLEN{1'b1}};
        end else if (ovf) begin
            finish_res = f3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else if (!f3[2]) begin
            prod = neg ? -acc : acc;
            finish_res = (f3[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
        end else begin
            part = f3[1] ? acc[W2-1:XLEN] : acc[XLEN-1:0];
            finish_res = neg ? -part : part;
        end
    endfunction

    // Operand magnitudes, result sign and corner-case flags from the raw inputs
    always_comb begin
        signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sa       = signed_a & op_a[XLEN-1];
        sb       = signed_b & op_b[XLEN-1];
        abs_a    = sa ? -op_a : op_a;
        abs_b    = sb ? -op_b : op_b;
        case (funct3)
            3'd1, 3'd4: neg_in = sa ^ sb;
            3'd2, 3'd6: neg_in = sa;
            default:    neg_in = 1'b0;
        endcase
        div0_in = funct3[2] && (op_b == {XLEN{1'b0}});
        ovf_in  = ((funct3 == 3'd4) || (funct3 == 3'd6))
                  && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                  && (op_b == {XLEN{1'b1}});
    end

    // One shift-add or restoring-divide step through a shared adder
    always_comb begin
        is_div     = f3_q[2];
        mul_addend = acc_q[0] ? dvs_q : {XLEN{1'b0}};
        if (is_div) begin
            add_a = {1'b0, acc_q[W2-1:XLEN-1]};
            add_b = ~{2'b00, dvs_q};
        end else begin
            add_a = {2'b00, acc_q[W2-1:XLEN]};
            add_b = {2'b00, mul_addend};
        end
        sum       = add_a + add_b + {{(XLEN+1){1'b0}}, is_div};
        no_borrow = ~sum[XLEN+1];
        if (is_div) begin
            acc_step = {(no_borrow ? sum[XLEN-1:0] : acc_q[W2-2:XLEN-1]),
                        acc_q[XLEN-2:0], no_borrow};
        end else begin
            acc_step = {sum[XLEN:0], acc_q[XLEN-1:1]};
        end
    end

    // Next-state logic: launch, iterate, finish, abort
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        neg_d     = neg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        a_raw_d   = a_raw_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        launch    = start && !kill;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (launch) begin
                    state_d = S_BUSY;
                    cnt_d   = {CNT_W{1'b0}};
                    f3_d    = funct3;
                    acc_d   = {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
                    dvs_d   = funct3[2] ? abs_b : abs_a;
                    neg_d   = neg_in;
                    div0_d  = div0_in;
                    ovf_d   = ovf_in;
                    a_raw_d = op_a;
                    rd_d    = rd_addr;
`ifdef MDU_EARLY_OUT_EN
                    if (div0_in || ovf_in) begin
                        state_d   = S_DONE;
                        wb_data_d = finish_res(funct3, {W2{1'b0}}, 1'b0, div0_in, ovf_in, op_a);
                    end
`endif
                end
            end
            S_BUSY: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d   = S_DONE;
                        wb_data_d = finish_res(f3_q, acc_step, neg_q, div0_q, ovf_q, a_raw_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            f3_q      <= 3'd0;
            acc_q     <= {W2{1'b0}};
            dvs_q     <= {XLEN{1'b0}};
            neg_q     <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            a_raw_q   <= {XLEN{1'b0}};
            rd_q      <= 5'd0;
            wb_data_q <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            neg_q     <= neg_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            a_raw_q   <= a_raw_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy    = (state_q == S_BUSY);
    assign done    = (state_q == S_DONE);
    assign wb_en   = done;
    assign wb_addr = rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter with a behavioural RV32M model
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = 32'd0;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit and signed 32-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb  = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p   = ea * eb;
        case (f3)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called at #1 after an edge; that cycle is cycle 0 of the operation.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string tag,
                         input bit chain, input int poke_cyc, output int got_cyc);
        int          lat;
        bit          busy_ok;
        logic [31:0] d;
        logic [4:0]  ad;
        logic        en, bz;
        lat      = (EARLY && is_special(f3, a, b)) ? 1 : 33;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        rd_addr  = rd;
        start    = 1'b1;
        got_cyc  = 0;
        busy_ok  = 1'b1;
        d = '0; ad = '0; en = 1'b0; bz = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (done) begin
                got_cyc = c;
                d  = wb_data;
                ad = wb_addr;
                en = wb_en;
                bz = busy;
                break;
            end
            if (busy !== (c < lat)) busy_ok = 1'b0;
            if (c == poke_cyc) begin
                start   = 1'b1;
                funct3  = f3 ^ 3'd1;
                op_a    = ~a;
                op_b    = a;
                rd_addr = rd + 5'd1;
            end
            if (c == poke_cyc + 1) start = 1'b0;
        end
        check({tag, ".latency"}, got_cyc, lat);
        check({tag, ".busy_pattern"}, busy_ok, 1);
        if (got_cyc != 0) begin
            check({tag, ".wb_data"}, d, exp);
            check({tag, ".wb_addr"}, ad, rd);
            check({tag, ".wb_en"}, en, 1);
            check({tag, ".busy_at_done"}, bz, 0);
        end
        last_exp = exp;
        if (!chain) begin
            @(posedge clk);
            #1;
            check({tag, ".done_pulse"}, done, 0);
        end
    endtask

    initial begin
        int          cyc1, cyc2, cyc;
        bit          saw_done;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          r;

        rst = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.wb_en", wb_en, 0);
        check("reset.wb_data", wb_data, 0);
        check("reset.wb_addr", wb_addr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, "mul",    0, 0, cyc);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, "mulh",   0, 0, cyc);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, "mulhu",  0, 0, cyc);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, "mulhsu", 0, 0, cyc);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, "div",    0, 0, cyc);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, "rem",    0, 0, cyc);
        do_op(3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        "divu",   0, 0, cyc);
        do_op(3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         "remu",   0, 0, cyc);
        do_op(3'd4, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, "div0",   0, 0, cyc);
        do_op(3'd6, 32'd5,         32'd0,         5'd12, 32'd5,         "rem0",   0, 0, cyc);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, "divovf", 0, 0, cyc);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         "removf", 0, 0, cyc);
        do_op(3'd0, 32'd9,         32'd9,         5'd0,  32'd81,        "x0dest", 0, 0, cyc);

        // start during BUSY must not re-latch
        do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0),
              "ignstart", 0, 5, cyc);

        // back-to-back: second start in the first DONE cycle
        do_op(3'd5, 32'd1000, 32'd3, 5'd16, 32'd333, "b2b1", 1, 0, cyc1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd5, 5'd17, 32'hFFFF_FFFF, "b2b2", 0, 0, cyc2);
        check("b2b.second_done_cycle", cyc1 + cyc2, 66);

        // kill mid-operation
        funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5; rd_addr = 5'd18; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill.busy", busy, 0);
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("kill.no_done", saw_done, 0);
        check("kill.wb_data_held", wb_data, last_exp);

        // kill blocks start in IDLE
        start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("idlekill.busy", busy, 0);
        check("idlekill.done", done, 0);

        // randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(1, 15));
            if (r == 3) a = 32'($urandom_range(0, 100));
            do_op(f3, a, b, 5'($urandom), model(f3, a, b), $sformatf("rand%0d_f%0d", i, f3), 0, 0, cyc);
        end

        // asynchronous reset mid-operation, with nonzero wb_data/wb_addr beforehand
        do_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, "prereset", 0, 0, cyc);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_addr = 5'd21; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        #3 rst = 1'b1;
        #1;
        check("arst.busy", busy, 0);
        check("arst.done", done, 0);
        check("arst.wb_en", wb_en, 0);
        check("arst.wb_data", wb_data, 0);
        check("arst.wb_addr", wb_addr, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst.idle_after", busy, 0);
        do_op(3'd0, 32'd6, 32'd7, 5'd22, 32'd42, "postreset", 0, 0, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
